sparse_mult_by_e_transpose: RTL and testbench

SPARSE_MULT_BY_E_TRANSPOSE -- requirements
Module: sparse_mult_by_E_transpose

---
 rtl/sparse_mult_by_e_transpose.sv | 123 ++++++++++++
 tb/tb_sparse_mult_by_e_transpose.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_mult_by_e_transpose.sv
// ---------------------------------------------------------------------------
// sparse_mult_by_e_transpose
//
// Expands each accepted input word into a frame of OUTPUT_LEN output beats.
// Every beat is zero except beat NZ_INDEX. That beat carries the captured word
// with each of its three lanes rotated right by SHIFT bits inside the lane.
//
// Parameters
//   WIDTH      data word width, three equal lanes of WIDTH/3 bits
//   OUTPUT_LEN number of output beats emitted per input word
//   NZ_INDEX   beat index that carries the non-zero block
//   SHIFT      per-lane circulant right rotation, 0..WIDTH/3-1
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_input_data   upstream word {high, mid, low}
//   i_input_valid  upstream valid
//   o_input_ready  upstream ready (high only while idle and out of reset)
//   o_output_data  downstream word
//   o_output_valid downstream valid
//   i_output_ready downstream ready
// ---------------------------------------------------------------------------
module sparse_mult_by_e_transpose #(
    parameter int WIDTH      = 96,
    parameter int OUTPUT_LEN = 11,
    parameter int NZ_INDEX   = 10,
    parameter int SHIFT      = 0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_input_data,
    input  logic             i_input_valid,
    output logic             o_input_ready,
    output logic [WIDTH-1:0] o_output_data,
    output logic             o_output_valid,
    input  logic             i_output_ready
);

    localparam int LANE = WIDTH / 3;
    localparam int BW   = $clog2(OUTPUT_LEN + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(OUTPUT_LEN - 1);
    localparam logic [BW-1:0] NZ_BEAT   = BW'(NZ_INDEX);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // Reject parameter sets that cannot describe a valid frame.
    if (WIDTH % 3 != 0) begin : g_bad_width
        $error("sparse_mult_by_e_transpose: WIDTH must be a multiple of 3");
    end
    if (OUTPUT_LEN < 1) begin : g_bad_len
        $error("sparse_mult_by_e_transpose: OUTPUT_LEN must be at least 1");
    end
    if (NZ_INDEX >= OUTPUT_LEN) begin : g_bad_nz
        $error("sparse_mult_by_e_transpose: NZ_INDEX must be below OUTPUT_LEN");
    end
    if (SHIFT >= WIDTH / 3) begin : g_bad_shift
        $error("sparse_mult_by_e_transpose: SHIFT must be below WIDTH/3");
    end

    // Rotate each lane right by SHIFT. A lane is doubled and shifted, so the
    // bits leaving the bottom come back in at the top of the same lane. No bit
    // crosses into a neighbouring lane.
    function automatic logic [WIDTH-1:0] rotate_lanes(input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0]  result;
        logic [LANE-1:0]   lane;
        logic [2*LANE-1:0] doubled;
        result = '0;
        for (int i = 0; i < 3; i++) begin
            lane    = word[i*LANE +: LANE];
            doubled = {lane, lane} >> SHIFT;
            result[i*LANE +: LANE] = doubled[LANE-1:0];
        end
        return result;
    endfunction

    logic [0:0]       state;
    logic [BW-1:0]    beat;
    logic [BW-1:0]    next_beat;
    logic [WIDTH-1:0] captured;
    logic [WIDTH-1:0] out_data_q;

    assign next_beat = beat + BW'(1);

    // Ready is gated by reset. This keeps it low while reset is held, and it
    // rises in the first cycle after reset is released.
    assign o_input_ready  = (state == ST_IDLE) && !i_reset;
    assign o_output_valid = (state == ST_EMIT);
    assign o_output_data  = out_data_q;

    // The frame sequencer. The data register is loaded one beat ahead, so
    // every output comes straight from a flop. During a downstream stall the
    // output data and valid are held unchanged.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            beat       <= '0;
            captured   <= '0;
            out_data_q <= '0;
        end else if (state == ST_IDLE) begin
            if (i_input_valid && o_input_ready) begin
                captured   <= i_input_data;
                beat       <= '0;
                state      <= ST_EMIT;
                out_data_q <= (NZ_BEAT == '0) ? rotate_lanes(i_input_data) : '0;
            end
        end else begin
            if (i_output_ready) begin
                if (beat == LAST_BEAT) begin
                    state      <= ST_IDLE;
                    beat       <= '0;
                    out_data_q <= '0;
                end else begin
                    beat       <= next_beat;
                    out_data_q <= (next_beat == NZ_BEAT) ? rotate_lanes(captured) : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_mult_by_e_transpose.sv
// ---------------------------------------------------------------------------
// tb_sparse_mult_by_e_transpose
//
// Self-checking bench with three instances:
//   dut     default parameters
//   dut_s4  SHIFT=4, driven in lockstep with dut
//   dut_one OUTPUT_LEN=1, NZ_INDEX=0, SHIFT=4, with its own handshake
// The expected beats come from a hand-written table and from a lane-rotation
// model that uses plain arithmetic.
// ---------------------------------------------------------------------------
module tb_sparse_mult_by_e_transpose;

    logic        clock = 1'b0;
    logic        reset;
    logic [95:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready4;
    logic [95:0] out_data;
    logic [95:0] out_data4;
    logic        out_valid;
    logic        out_valid4;
    logic        out_ready;

    logic [95:0] one_in_data;
    logic        one_in_valid;
    logic        one_in_ready;
    logic [95:0] one_out_data;
    logic        one_out_valid;
    logic        one_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] got[$];
    logic [95:0] got4[$];
    int fr_ready_low;
    int fr_stall_err;
    int fr_early;

    typedef struct {
        logic [95:0] word;
        logic [95:0] exp_s0;
        logic [95:0] exp_s4;
    } vec_t;
    vec_t vecs[5];

    always #5 clock = ~clock;

    sparse_mult_by_e_transpose dut (
        .i_clock(clock), .i_reset(reset),
        .i_input_data(in_data), .i_input_valid(in_valid), .o_input_ready(in_ready),
        .o_output_data(out_data), .o_output_valid(out_valid), .i_output_ready(out_ready)
    );

    sparse_mult_by_e_transpose #(.SHIFT(4)) dut_s4 (
        .i_clock(clock), .i_reset(reset),
        .i_input_data(in_data), .i_input_valid(in_valid), .o_input_ready(in_ready4),
        .o_output_data(out_data4), .o_output_valid(out_valid4), .i_output_ready(out_ready)
    );

    sparse_mult_by_e_transpose #(.OUTPUT_LEN(1), .NZ_INDEX(0), .SHIFT(4)) dut_one (
        .i_clock(clock), .i_reset(reset),
        .i_input_data(one_in_data), .i_input_valid(one_in_valid), .o_input_ready(one_in_ready),
        .o_output_data(one_out_data), .o_output_valid(one_out_valid), .i_output_ready(one_out_ready)
    );

    // Reference beat: zero off the non-zero index, otherwise each 32-bit lane
    // rotated right by s using 64-bit arithmetic.
    function automatic logic [95:0] model_beat(input logic [95:0] w, input int k,
                                               input int s, input int nz);
        logic [95:0]    res;
        longint unsigned v;
        longint unsigned r;
        res = '0;
        if (k == nz) begin
            for (int i = 0; i < 3; i++) begin
                v = longint'(w[32*i +: 32]);
                r = ((v >> s) | (v << (32 - s))) & 64'hFFFF_FFFF;
                res[32*i +: 32] = r[31:0];
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] actual,
                               input logic [95:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offer a word on the shared input and wait, bounded, for its acceptance.
    // The task returns at the first negedge after the transfer edge.
    task automatic sendWord(input logic [95:0] w);
        int g = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        checkOutput("input_accepted", 96'(in_ready), 96'd1);
        @(negedge clock);
    endtask

    // Gather one frame under the chosen ready pattern.
    // Mode 0 holds ready high, mode 1 toggles it every cycle, mode 2 is random.
    // Any change of output while stalled is counted, as is any cycle where
    // ready is seen high before the frame ends.
    task automatic collectFrame(input int mode);
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic [95:0] prev_d = '0;
        logic [95:0] prev_d4 = '0;
        got.delete();
        got4.delete();
        fr_ready_low = 0;
        fr_stall_err = 0;
        fr_early     = 0;
        while (got.size() < 11 && cyc < 300) begin
            if (!in_ready) fr_ready_low++;
            else fr_early++;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d || out_data4 !== prev_d4))
                fr_stall_err++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got4.push_back(out_data4);
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_d4    = out_data4;
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic applyStimulus(input logic [95:0] w, input int mode, input bit offer_second);
        sendWord(w);
        if (offer_second) in_data = ~w;
        else in_valid = 1'b0;
        collectFrame(mode);
    endtask

    // Compare a collected frame beat by beat. Beat 10 must equal the given
    // non-zero values, and every other beat must be zero.
    task automatic checkFrame(input string tag, input logic [95:0] nz_s0, input logic [95:0] nz_s4);
        logic [95:0] a;
        logic [95:0] a4;
        checkOutput({tag, "_beat_count"}, 96'(got.size()), 96'd11);
        for (int k = 0; k < 11; k++) begin
            a  = (k < got.size())  ? got[k]  : 'x;
            a4 = (k < got4.size()) ? got4[k] : 'x;
            checkOutput($sformatf("%s_s0_beat%0d", tag, k), a,  (k == 10) ? nz_s0 : 96'd0);
            checkOutput($sformatf("%s_s4_beat%0d", tag, k), a4, (k == 10) ? nz_s4 : 96'd0);
        end
    endtask

    initial begin
        int          xfers;
        int          ready_low;
        int          cnt;
        int          g;
        int          frames;
        logic [95:0] w;

        vecs[0] = '{ {32'd67108896, 32'd65536, 32'd134217792},
                     {32'd67108896, 32'd65536, 32'd134217792},
                     {32'h0040_0002, 32'h0000_1000, 32'h0080_0004} };
        vecs[1] = '{ {32'h0000_000F, 32'h8000_0000, 32'h0000_0001},
                     {32'h0000_000F, 32'h8000_0000, 32'h0000_0001},
                     {32'hF000_0000, 32'h0800_0000, 32'h1000_0000} };
        vecs[2] = '{ {32'h0000_000A, 32'hFFFF_FFF0, 32'h1234_5678},
                     {32'h0000_000A, 32'hFFFF_FFF0, 32'h1234_5678},
                     {32'hA000_0000, 32'h0FFF_FFFF, 32'h8123_4567} };
        vecs[3] = '{ {96{1'b1}}, {96{1'b1}}, {96{1'b1}} };
        vecs[4] = '{ 96'd0, 96'd0, 96'd0 };

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        one_in_valid = 1'b0;
        one_in_data = '0;
        one_out_ready = 1'b0;

        // Check the outputs while reset is held.
        repeat (3) @(negedge clock);
        checkOutput("reset_out_valid", 96'(out_valid), 96'd0);
        checkOutput("reset_out_data", out_data, 96'd0);
        checkOutput("reset_in_ready", 96'(in_ready), 96'd0);
        checkOutput("reset_one_in_ready", 96'(one_in_ready), 96'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 96'(in_ready), 96'd1);
        @(negedge clock);

        // Idle for 100 cycles with ready high: no transfers, ready always high.
        xfers = 0;
        ready_low = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) xfers++;
            if (!in_ready) ready_low++;
            @(negedge clock);
        end
        checkOutput("idle_transfers", 96'(xfers), 96'd0);
        checkOutput("idle_ready_low", 96'(ready_low), 96'd0);

        // Run each table vector as one full frame with ready held high.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].word, 0, 1'b0);
            checkFrame($sformatf("vec%0d", v), vecs[v].exp_s0, vecs[v].exp_s4);
            checkOutput($sformatf("vec%0d_ready_low_cycles", v), 96'(fr_ready_low), 96'd11);
            checkOutput($sformatf("vec%0d_ready_after", v), 96'(in_ready), 96'd1);
            checkOutput($sformatf("vec%0d_valid_after", v), 96'(out_valid), 96'd0);
        end

        // Toggle ready every cycle while a second word is offered during the
        // frame. The second word must wait until beat 10 has transferred.
        applyStimulus(vecs[0].word, 1, 1'b1);
        checkFrame("toggle", vecs[0].exp_s0, vecs[0].exp_s4);
        checkOutput("toggle_stall_stable", 96'(fr_stall_err), 96'd0);
        checkOutput("toggle_no_early_ready", 96'(fr_early), 96'd0);
        checkOutput("toggle_ready_after", 96'(in_ready), 96'd1);
        @(negedge clock);
        in_valid = 1'b0;
        checkOutput("second_word_started", 96'(out_valid), 96'd1);
        collectFrame(0);
        checkFrame("second", ~vecs[0].word, model_beat(~vecs[0].word, 10, 4, 10));

        // Assert reset after beat 4 has transferred, then send a word of 0.
        w = {$urandom, $urandom, $urandom};
        sendWord(w);
        in_valid = 1'b0;
        cnt = 0;
        g = 0;
        while (cnt < 5 && g < 50) begin
            out_ready = 1'b1;
            if (out_valid) cnt++;
            @(negedge clock);
            g++;
        end
        checkOutput("midframe_beats_before_reset", 96'(cnt), 96'd5);
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset_out_valid", 96'(out_valid), 96'd0);
        checkOutput("midreset_out_data", out_data, 96'd0);
        checkOutput("midreset_in_ready", 96'(in_ready), 96'd0);
        reset = 1'b0;
        #1;
        checkOutput("midreset_release_ready", 96'(in_ready), 96'd1);
        @(negedge clock);
        xfers = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) xfers++;
            @(negedge clock);
        end
        checkOutput("abandoned_frame_silent", 96'(xfers), 96'd0);
        applyStimulus(96'd0, 0, 1'b0);
        checkFrame("after_reset", 96'd0, 96'd0);
        checkOutput("after_reset_ready_low", 96'(fr_ready_low), 96'd11);

        // Loopback with random stall patterns: the non-zero beat of the SHIFT=0
        // instance recovers the original word.
        frames = 0;
        for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom, $urandom};
            applyStimulus(w, 2, 1'b0);
            if (got.size() == 11) frames++;
            checkOutput($sformatf("loop%0d_recovered", i), (got.size() == 11) ? got[10] : 'x, w);
            checkFrame($sformatf("loop%0d", i), model_beat(w, 10, 0, 10), model_beat(w, 10, 4, 10));
            checkOutput($sformatf("loop%0d_stall_stable", i), 96'(fr_stall_err), 96'd0);
        end
        checkOutput("loop_frame_count", 96'(frames), 96'd5);

        // A single-beat frame, including one cycle of stall.
        @(negedge clock);
        one_in_valid = 1'b1;
        one_in_data = vecs[1].word;
        checkOutput("one_ready_idle", 96'(one_in_ready), 96'd1);
        @(negedge clock);
        one_in_valid = 1'b0;
        checkOutput("one_valid", 96'(one_out_valid), 96'd1);
        checkOutput("one_data", one_out_data, vecs[1].exp_s4);
        checkOutput("one_ready_busy", 96'(one_in_ready), 96'd0);
        @(negedge clock);
        checkOutput("one_stall_data", one_out_data, vecs[1].exp_s4);
        one_out_ready = 1'b1;
        @(negedge clock);
        checkOutput("one_valid_after", 96'(one_out_valid), 96'd0);
        checkOutput("one_ready_after", 96'(one_in_ready), 96'd1);
        checkOutput("one_data_after", one_out_data, 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
